// File: rtl/glm_dma_read_engine.sv
// DMA read engine: converts tx read tokens into memory read requests and returns lines in order via a ROB.
// Define DMA_READ_PERF_EN to add perf_stall_cycles / perf_lines counters.
`timescale 1ns/1ps
module glm_dma_read_engine #(
    parameter int LOG2_ROB_DEPTH = 5,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int CLADDR_WIDTH   = 42,
    parameter int CLDATA_WIDTH   = 512
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ctrl_start,
    input  logic [CLADDR_WIDTH-1:0]   ctrl_addr,
    input  logic [31:0]               ctrl_reg4,
    output logic                      status_idle,
    output logic                      status_active,
    output logic                      status_done,
    input  logic                      tx_re,
    input  logic [1:0]                tx_rlength,
    output logic                      tx_almostfull,
    output logic                      rx_rvalid,
    output logic [CLDATA_WIDTH-1:0]   rx_rdata,
    output logic                      mem_req_valid,
    output logic [CLADDR_WIDTH-1:0]   mem_req_addr,
    output logic [1:0]                mem_req_len,
    output logic [LOG2_ROB_DEPTH-1:0] mem_req_tag,
    input  logic                      mem_req_almostfull,
    input  logic                      mem_rsp_valid,
    input  logic [LOG2_ROB_DEPTH-1:0] mem_rsp_tag,
    input  logic [1:0]                mem_rsp_clnum,
    input  logic [CLDATA_WIDTH-1:0]   mem_rsp_data,
`ifdef DMA_READ_PERF_EN
    output logic [31:0]               perf_stall_cycles,
    output logic [31:0]               perf_lines,
`endif
    output logic [1:0]                err_sticky
);
    localparam int ROB_DEPTH = 1 << LOG2_ROB_DEPTH;
    localparam int TW        = LOG2_ROB_DEPTH;
    localparam int FW        = LOG2_ROB_DEPTH + 1;
    localparam int QW        = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
    localparam int CW        = $clog2(CMD_FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam logic [CW-1:0] FIFO_FULL = CW'(CMD_FIFO_DEPTH);
    localparam logic [CW-1:0] FIFO_AF   = CW'(CMD_FIFO_DEPTH - 2);
    localparam logic [QW-1:0] FIFO_LAST = QW'(CMD_FIFO_DEPTH - 1);
    localparam logic [FW-1:0] ROB_SLOTS = FW'(ROB_DEPTH);

    logic [1:0]              state;
    logic [CLADDR_WIDTH-1:0] job_base;
    logic [30:0]             job_len;
    logic                    job_ml;
    logic [30:0]             issued;
    logic [30:0]             delivered;
    logic                    done_q;
    logic [1:0]              err_q;

    logic [1:0]              fifo_mem [CMD_FIFO_DEPTH];
    logic [QW-1:0]           fifo_wp;
    logic [QW-1:0]           fifo_rp;
    logic [CW-1:0]           fifo_cnt;

    logic                    split_act;
    logic [2:0]              split_cnt;

    logic [TW-1:0]           wr_ptr;
    logic [TW-1:0]           rd_ptr;
    logic [FW-1:0]           free_cnt;
    logic [ROB_DEPTH-1:0]    rob_rsv;
    logic [ROB_DEPTH-1:0]    rob_vld;
    logic [ROB_DEPTH-1:0]    rsv_nxt;
    logic [ROB_DEPTH-1:0]    vld_nxt;
    logic [CLDATA_WIDTH-1:0] rob_data [ROB_DEPTH];

    logic                    start_ok;
    logic [1:0]              head_rl;
    logic [2:0]              head_n;
    logic [2:0]              rem_n;
    logic [2:0]              req_n;
    logic [CLADDR_WIDTH-1:0] cur_addr;
    logic                    head_valid;
    logic                    tok_bad;
    logic                    misal;
    logic                    blocked;
    logic                    do_drop;
    logic                    do_issue;
    logic                    split_last;
    logic                    do_pop;
    logic                    do_push;
    logic                    push_ovf;
    logic                    drain;
    logic [TW-1:0]           rsp_slot;
    logic                    rsp_ok;

    assign status_idle   = (state == S_IDLE);
    assign status_active = (state == S_ACTIVE);
    assign status_done   = done_q;
    assign err_sticky    = err_q;
    assign tx_almostfull = (fifo_cnt >= FIFO_AF);

    assign start_ok = ctrl_start && (state == S_IDLE);
    assign head_rl  = fifo_mem[fifo_rp];

    always_comb begin
        case (head_rl)
            2'b00:   head_n = 3'd1;
            2'b01:   head_n = 3'd2;
            2'b11:   head_n = 3'd4;
            default: head_n = 3'd0;
        endcase
    end

    // A split token keeps its misaligned status until its last single-line piece issues.
    assign rem_n      = head_n - split_cnt;
    assign cur_addr   = job_base + CLADDR_WIDTH'(issued);
    assign head_valid = (fifo_cnt != '0) && (state != S_IDLE);
    assign tok_bad    = (head_rl == 2'b10) || (!job_ml && (head_n != 3'd1)) ||
                        (({1'b0, issued} + 32'(rem_n)) > {1'b0, job_len});
    assign misal      = split_act ||
                        ((head_n != 3'd1) && ((cur_addr[1:0] & (head_n[1:0] - 2'd1)) != 2'b00));
    assign req_n      = misal ? 3'd1 : head_n;
    assign blocked    = (free_cnt < FW'(req_n)) || mem_req_almostfull;
    assign do_drop    = head_valid && tok_bad;
    assign do_issue   = head_valid && !tok_bad && !blocked;
    assign split_last = ((split_cnt + 3'd1) == head_n);
    assign do_pop     = do_drop || (do_issue && (!misal || split_last));
    assign do_push    = tx_re && (state == S_ACTIVE) && (fifo_cnt != FIFO_FULL);
    assign push_ovf   = tx_re && (state == S_ACTIVE) && (fifo_cnt == FIFO_FULL);

    assign drain    = rob_vld[rd_ptr];
    assign rsp_slot = mem_rsp_tag + TW'(mem_rsp_clnum);
    assign rsp_ok   = mem_rsp_valid && rob_rsv[rsp_slot] && !(drain && (rsp_slot == rd_ptr));

    always_comb begin
        rsv_nxt = rob_rsv;
        vld_nxt = rob_vld;
        if (drain) begin
            rsv_nxt[rd_ptr] = 1'b0;
            vld_nxt[rd_ptr] = 1'b0;
        end
        if (do_issue) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (3'(i) < req_n) rsv_nxt[wr_ptr + TW'(i)] = 1'b1;
            end
        end
        if (rsp_ok) vld_nxt[rsp_slot] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rsp_ok) rob_data[rsp_slot] <= mem_rsp_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            job_base      <= '0;
            job_len       <= '0;
            job_ml        <= 1'b0;
            issued        <= '0;
            delivered     <= '0;
            done_q        <= 1'b0;
            err_q         <= '0;
            fifo_wp       <= '0;
            fifo_rp       <= '0;
            fifo_cnt      <= '0;
            for (int unsigned i = 0; i < CMD_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            split_act     <= 1'b0;
            split_cnt     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            free_cnt      <= ROB_SLOTS;
            rob_rsv       <= '0;
            rob_vld       <= '0;
            rx_rvalid     <= 1'b0;
            rx_rdata      <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_len   <= '0;
            mem_req_tag   <= '0;
        end else begin
            done_q        <= 1'b0;
            mem_req_valid <= do_issue;
            rx_rvalid     <= drain;
            rob_rsv       <= rsv_nxt;
            rob_vld       <= vld_nxt;
            free_cnt      <= free_cnt + FW'(drain) - (do_issue ? FW'(req_n) : '0);

            if (start_ok) err_q <= '0;
            else          err_q <= err_q | {do_drop || push_ovf, do_issue && misal};

            case (state)
                S_IDLE: if (start_ok) begin
                    if (ctrl_reg4[30:0] != '0) begin
                        state     <= S_ACTIVE;
                        job_base  <= ctrl_addr;
                        job_len   <= ctrl_reg4[30:0];
                        job_ml    <= ctrl_reg4[31];
                        issued    <= '0;
                        delivered <= '0;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                S_ACTIVE: if (issued == job_len) state <= S_DRAIN;
                S_DRAIN: if (delivered == job_len) begin
                    state  <= S_IDLE;
                    done_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase

            if (do_issue) begin
                mem_req_addr <= cur_addr;
                mem_req_len  <= misal ? 2'b00 : head_rl;
                mem_req_tag  <= wr_ptr;
                wr_ptr       <= wr_ptr + TW'(req_n);
                issued       <= issued + 31'(req_n);
                if (misal) begin
                    split_act <= !split_last;
                    split_cnt <= split_last ? 3'd0 : split_cnt + 3'd1;
                end
            end

            if (drain) begin
                rx_rdata  <= rob_data[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
                delivered <= delivered + 31'd1;
            end

            if (start_ok) begin
                fifo_wp  <= '0;
                fifo_rp  <= '0;
                fifo_cnt <= '0;
            end else begin
                if (do_push) begin
                    fifo_mem[fifo_wp] <= tx_rlength;
                    fifo_wp <= (fifo_wp == FIFO_LAST) ? '0 : fifo_wp + 1'b1;
                end
                if (do_pop) fifo_rp <= (fifo_rp == FIFO_LAST) ? '0 : fifo_rp + 1'b1;
                fifo_cnt <= fifo_cnt + CW'(do_push) - CW'(do_pop);
            end
        end
    end

`ifdef DMA_READ_PERF_EN
    logic stall_cycle;
    assign stall_cycle = head_valid && !tok_bad && blocked;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
            perf_lines        <= '0;
        end else if (start_ok) begin
            perf_stall_cycles <= '0;
            perf_lines        <= '0;
        end else begin
            if (stall_cycle && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (drain && (perf_lines != '1))              perf_lines        <= perf_lines + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_glm_dma_read_engine.sv
// Scoreboard bench for glm_dma_read_engine: directed jobs on a 32-slot and a 4-slot ROB instance.
`timescale 1ns/1ps
module tb_glm_dma_read_engine;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  len;
        logic [4:0]  tag;
    } req_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel_b;
    logic        ctrl_start;
    logic [31:0] ctrl_addr;
    logic [31:0] ctrl_reg4;
    logic        tx_re;
    logic [1:0]  tx_rlength;
    logic        mem_req_almostfull;
    logic        mem_rsp_valid;
    logic [4:0]  mem_rsp_tag;
    logic [1:0]  mem_rsp_clnum;
    logic [63:0] mem_rsp_data;

    logic        a_idle, a_active, a_done, a_af, a_rxv, a_reqv;
    logic [63:0] a_rxd;
    logic [31:0] a_addr;
    logic [1:0]  a_len, a_err;
    logic [4:0]  a_tag;
    logic        b_idle, b_active, b_done, b_af, b_rxv, b_reqv;
    logic [63:0] b_rxd;
    logic [31:0] b_addr;
    logic [1:0]  b_len, b_err;
    logic [1:0]  b_tag;

    logic        m_idle, m_active, m_done, m_af, m_rxv, m_reqv;
    logic [63:0] m_rxd;
    logic [31:0] m_addr;
    logic [1:0]  m_len, m_err;
    logic [4:0]  m_tag;

    int   n_cmp = 0;
    int   n_err = 0;
    req_t req_q[$];
    logic [63:0] rx_q[$];

    always #5 clk = ~clk;

    glm_dma_read_engine #(.LOG2_ROB_DEPTH(5), .CMD_FIFO_DEPTH(4), .CLADDR_WIDTH(32), .CLDATA_WIDTH(64)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .ctrl_start(ctrl_start && !sel_b), .ctrl_addr(ctrl_addr), .ctrl_reg4(ctrl_reg4),
        .status_idle(a_idle), .status_active(a_active), .status_done(a_done),
        .tx_re(tx_re && !sel_b), .tx_rlength(tx_rlength), .tx_almostfull(a_af),
        .rx_rvalid(a_rxv), .rx_rdata(a_rxd),
        .mem_req_valid(a_reqv), .mem_req_addr(a_addr), .mem_req_len(a_len), .mem_req_tag(a_tag),
        .mem_req_almostfull(mem_req_almostfull),
        .mem_rsp_valid(mem_rsp_valid && !sel_b), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_clnum(mem_rsp_clnum), .mem_rsp_data(mem_rsp_data),
        .err_sticky(a_err)
    );

    glm_dma_read_engine #(.LOG2_ROB_DEPTH(2), .CMD_FIFO_DEPTH(4), .CLADDR_WIDTH(32), .CLDATA_WIDTH(64)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .ctrl_start(ctrl_start && sel_b), .ctrl_addr(ctrl_addr), .ctrl_reg4(ctrl_reg4),
        .status_idle(b_idle), .status_active(b_active), .status_done(b_done),
        .tx_re(tx_re && sel_b), .tx_rlength(tx_rlength), .tx_almostfull(b_af),
        .rx_rvalid(b_rxv), .rx_rdata(b_rxd),
        .mem_req_valid(b_reqv), .mem_req_addr(b_addr), .mem_req_len(b_len), .mem_req_tag(b_tag),
        .mem_req_almostfull(mem_req_almostfull),
        .mem_rsp_valid(mem_rsp_valid && sel_b), .mem_rsp_tag(mem_rsp_tag[1:0]),
        .mem_rsp_clnum(mem_rsp_clnum), .mem_rsp_data(mem_rsp_data),
        .err_sticky(b_err)
    );

    assign m_idle   = sel_b ? b_idle   : a_idle;
    assign m_active = sel_b ? b_active : a_active;
    assign m_done   = sel_b ? b_done   : a_done;
    assign m_af     = sel_b ? b_af     : a_af;
    assign m_rxv    = sel_b ? b_rxv    : a_rxv;
    assign m_rxd    = sel_b ? b_rxd    : a_rxd;
    assign m_reqv   = sel_b ? b_reqv   : a_reqv;
    assign m_addr   = sel_b ? b_addr   : a_addr;
    assign m_len    = sel_b ? b_len    : a_len;
    assign m_tag    = sel_b ? {3'b000, b_tag} : a_tag;
    assign m_err    = sel_b ? b_err    : a_err;

    // Monitor: every presented request / rx line is matched against the head of its queue.
    initial begin : monitor
        req_t        e;
        logic [63:0] d;
        forever begin
            @(negedge clk);
            if (m_reqv) begin
                n_cmp++;
                if (req_q.size() == 0) begin
                    n_err++;
                    $display("FAIL mem_req_unexpected: got addr=%h len=%b tag=%0d, required no request", m_addr, m_len, m_tag);
                end else begin
                    e = req_q.pop_front();
                    if (m_addr !== e.addr || m_len !== e.len || m_tag !== e.tag) begin
                        n_err++;
                        $display("FAIL mem_req: got addr=%h len=%b tag=%0d, required addr=%h len=%b tag=%0d",
                                 m_addr, m_len, m_tag, e.addr, e.len, e.tag);
                    end
                end
            end
            if (m_rxv) begin
                n_cmp++;
                if (rx_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rx_unexpected: got data=%h, required no rx line", m_rxd);
                end else begin
                    d = rx_q.pop_front();
                    if (m_rxd !== d) begin
                        n_err++;
                        $display("FAIL rx_data: got %h, required %h", m_rxd, d);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_job(input logic [31:0] addr, input logic [31:0] reg4);
        ctrl_addr  = addr;
        ctrl_reg4  = reg4;
        ctrl_start = 1'b1;
        @(negedge clk);
        ctrl_start = 1'b0;
    endtask

    task automatic token(input logic [1:0] rl);
        tx_rlength = rl;
        tx_re      = 1'b1;
        @(negedge clk);
        tx_re      = 1'b0;
    endtask

    task automatic rsp(input logic [4:0] tag, input logic [1:0] cl, input logic [63:0] d);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = tag;
        mem_rsp_clnum = cl;
        mem_rsp_data  = d;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (m_done) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd1);
    endtask

    function automatic logic [63:0] dat(input int t, input int l);
        return 64'hCAFE_0000_0000_0000 | (64'(t) << 32) | 64'(l);
    endfunction

    function automatic req_t mk(input logic [31:0] a, input logic [1:0] l, input logic [4:0] t);
        req_t r;
        r.addr = a;
        r.len  = l;
        r.tag  = t;
        return r;
    endfunction

    initial begin : watchdog
        #200000;
        n_err++;
        $display("FAIL watchdog: got no completion, required bench to finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : stim
        reset_n = 1'b0; sel_b = 1'b0; ctrl_start = 1'b0; ctrl_addr = '0; ctrl_reg4 = '0;
        tx_re = 1'b0; tx_rlength = '0; mem_req_almostfull = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_tag = '0; mem_rsp_clnum = '0; mem_rsp_data = '0;
        tick(3);
        check("reset_idle",   64'(m_idle),   64'd1);
        check("reset_active", 64'(m_active), 64'd0);
        check("reset_done",   64'(m_done),   64'd0);
        check("reset_reqv",   64'(m_reqv),   64'd0);
        check("reset_rxv",    64'(m_rxv),    64'd0);
        check("reset_af",     64'(m_af),     64'd0);
        check("reset_err",    64'(m_err),    64'd0);
        reset_n = 1'b1;
        tick(2);

        // Job 1: two aligned 4-line tokens, in-order responses.
        req_q.push_back(mk(32'h1000, 2'b11, 5'd0));
        req_q.push_back(mk(32'h1004, 2'b11, 5'd4));
        for (int i = 0; i < 8; i++) rx_q.push_back(dat(1, i));
        start_job(32'h1000, 32'h8000_0008);
        check("j1_active", 64'(m_active), 64'd1);
        check("j1_idle",   64'(m_idle),   64'd0);
        token(2'b11);
        token(2'b11);
        tick(4);
        check("j1_reqs_issued", 64'(req_q.size()), 64'd0);
        for (int i = 0; i < 8; i++) rsp((i < 4) ? 5'd0 : 5'd4, 2'(i % 4), dat(1, i));
        wait_done("j1_done");
        tick(1);
        check("j1_idle_after", 64'(m_idle), 64'd1);
        check("j1_err",        64'(m_err),  64'd0);

        // Job 2: out-of-order clnum 3,1,0,2; first rx two cycles after clnum 0.
        req_q.push_back(mk(32'h2000, 2'b11, 5'd0));
        for (int i = 0; i < 4; i++) rx_q.push_back(dat(2, i));
        start_job(32'h2000, 32'h8000_0004);
        token(2'b11);
        tick(5);
        rsp(5'd0, 2'd3, dat(2, 3));
        rsp(5'd0, 2'd1, dat(2, 1));
        mem_rsp_valid = 1'b1; mem_rsp_tag = 5'd0; mem_rsp_clnum = 2'd0; mem_rsp_data = dat(2, 0);
        @(negedge clk);
        check("j2_rx_not_early", 64'(m_rxv), 64'd0);
        mem_rsp_clnum = 2'd2; mem_rsp_data = dat(2, 2);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("j2_rx_latency2", 64'(m_rxv), 64'd1);
        wait_done("j2_done");
        tick(1);
        check("j2_rx_drained", 64'(rx_q.size()), 64'd0);

        // Job 3 on the 4-slot ROB: second 4-line request waits for all four lines to drain.
        sel_b = 1'b1;
        tick(1);
        req_q.push_back(mk(32'h3000, 2'b11, 5'd0));
        for (int i = 0; i < 8; i++) rx_q.push_back(dat(3, i));
        start_job(32'h3000, 32'h8000_0008);
        token(2'b11);
        token(2'b11);
        tick(6);
        check("j3_first_issued", 64'(req_q.size()), 64'd0);
        check("j3_af_low",       64'(m_af),         64'd0);
        token(2'b11);
        check("j3_af_high",      64'(m_af),         64'd1);
        req_q.push_back(mk(32'h3004, 2'b11, 5'd0));
        for (int i = 0; i < 3; i++) rsp(5'd0, 2'(i), dat(3, i));
        tick(6);
        check("j3_second_held", 64'(req_q.size()), 64'd1);
        rsp(5'd0, 2'd3, dat(3, 3));
        for (int i = 0; i < 20 && req_q.size() != 0; i++) tick(1);
        check("j3_second_issued", 64'(req_q.size()), 64'd0);
        for (int i = 4; i < 8; i++) rsp(5'd0, 2'(i - 4), dat(3, i));
        wait_done("j3_done");
        check("j3_err_drop", 64'(m_err), 64'd2);
        tick(1);
        sel_b = 1'b0;
        tick(1);

        // Job 4: zero length.
        start_job(32'h0, 32'h8000_0000);
        check("j4_done_pulse", 64'(m_done),   64'd1);
        check("j4_idle",       64'(m_idle),   64'd1);
        check("j4_active",     64'(m_active), 64'd0);
        tick(1);
        check("j4_done_cleared", 64'(m_done), 64'd0);
        tick(3);

        // Job 5: misaligned 2-line token splits; over-length token dropped.
        req_q.push_back(mk(32'h1001, 2'b00, 5'd0));
        req_q.push_back(mk(32'h1002, 2'b00, 5'd1));
        for (int i = 0; i < 3; i++) rx_q.push_back(dat(5, i));
        start_job(32'h1001, 32'h8000_0003);
        token(2'b01);
        tick(4);
        check("j5_err_misaligned", 64'(m_err), 64'd1);
        check("j5_split_issued", 64'(req_q.size()), 64'd0);
        token(2'b01);
        tick(3);
        check("j5_err_overlength", 64'(m_err), 64'd3);
        req_q.push_back(mk(32'h1003, 2'b00, 5'd2));
        token(2'b00);
        tick(4);
        for (int i = 0; i < 3; i++) rsp(5'(i), 2'd0, dat(5, i));
        wait_done("j5_done");
        check("j5_err_sticky", 64'(m_err), 64'd3);
        tick(2);

        // Job 6: reset mid-job with three lines in flight, then a clean job.
        req_q.push_back(mk(32'h4000, 2'b00, 5'd0));
        req_q.push_back(mk(32'h4001, 2'b00, 5'd1));
        req_q.push_back(mk(32'h4002, 2'b00, 5'd2));
        start_job(32'h4000, 32'h0000_0008);
        check("j6_err_cleared", 64'(m_err), 64'd0);
        token(2'b00);
        token(2'b00);
        token(2'b00);
        tick(4);
        check("j6_reqs_issued", 64'(req_q.size()), 64'd0);
        reset_n = 1'b0;
        #1;
        check("j6_idle_in_reset",   64'(m_idle),   64'd1);
        check("j6_active_in_reset", 64'(m_active), 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) rsp(5'(i), 2'd0, dat(6, i));
        tick(5);
        req_q.push_back(mk(32'h5000, 2'b00, 5'd0));
        rx_q.push_back(dat(7, 0));
        start_job(32'h5000, 32'h0000_0001);
        token(2'b00);
        tick(4);
        rsp(5'd0, 2'd0, dat(7, 0));
        wait_done("j7_done");
        tick(2);

        check("final_req_q_empty", 64'(req_q.size()), 64'd0);
        check("final_rx_q_empty",  64'(rx_q.size()),  64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
